// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with a MULT/DIV occupancy sequencer for the ID/EX boundary.
// The sequencer exists only when ALU_CTRL_MULDIV_EN is defined; otherwise mult/div functs decode as illegal.
module alu_ctrl_seq #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] ALUop,
    input  logic [5:0] funct,
    input  logic [5:0] opcode,
    input  logic       flush,
    output logic       out_valid,
    output logic [3:0] ALUctrl,
    output logic       illegal,
    output logic       md_busy,
    output logic       md_div,
    output logic       md_unsigned,
    output logic       hilo_we
);

    // Result packing: {is_muldiv, illegal, ctrl[3:0]}
    function automatic logic [5:0] decode(input logic [1:0] aluop,
                                          input logic [5:0] fn,
                                          input logic [5:0] op);
        logic [5:0] res;
        res = {1'b0, 1'b1, 4'b0010};
        case (aluop)
            2'b00: res = {1'b0, 1'b0, 4'b0010};
            2'b01: res = {1'b0, 1'b0, 4'b0110};
            2'b10: begin
                case (fn)
                    6'b100000, 6'b100001: res = {1'b0, 1'b0, 4'b0010};
                    6'b100010, 6'b100011: res = {1'b0, 1'b0, 4'b0110};
                    6'b100100:            res = {1'b0, 1'b0, 4'b0000};
                    6'b100101:            res = {1'b0, 1'b0, 4'b0001};
                    6'b100110:            res = {1'b0, 1'b0, 4'b0011};
                    6'b100111:            res = {1'b0, 1'b0, 4'b1100};
                    6'b101010:            res = {1'b0, 1'b0, 4'b0111};
                    6'b000000:            res = {1'b0, 1'b0, 4'b1000};
                    6'b000010:            res = {1'b0, 1'b0, 4'b1001};
                    6'b000011:            res = {1'b0, 1'b0, 4'b1010};
`ifdef ALU_CTRL_MULDIV_EN
                    6'b011000, 6'b011001: res = {1'b1, 1'b0, 4'b1101};
                    6'b011010, 6'b011011: res = {1'b1, 1'b0, 4'b1110};
`endif
                    default:              res = {1'b0, 1'b1, 4'b0010};
                endcase
            end
            2'b11: begin
                case (op)
                    6'b001000, 6'b001001: res = {1'b0, 1'b0, 4'b0010};
                    6'b001100:            res = {1'b0, 1'b0, 4'b0000};
                    6'b001101:            res = {1'b0, 1'b0, 4'b0001};
                    6'b001110:            res = {1'b0, 1'b0, 4'b0011};
                    6'b001010:            res = {1'b0, 1'b0, 4'b0111};
                    6'b001111:            res = {1'b0, 1'b0, 4'b1011};
                    default:              res = {1'b0, 1'b1, 4'b0010};
                endcase
            end
            default: res = {1'b0, 1'b1, 4'b0010};
        endcase
        return res;
    endfunction

    logic [5:0] dec_s;
    logic       accept_s;
    logic       out_valid_r;
    logic [3:0] alu_ctrl_r;
    logic       illegal_r;

    assign dec_s    = decode(ALUop, funct, opcode);
    assign accept_s = in_valid & in_ready & ~flush;

    // Output stage: load on accepted transfer, flush and idle cycles only drop valid
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            alu_ctrl_r  <= 4'b0000;
            illegal_r   <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            alu_ctrl_r  <= dec_s[3:0];
            illegal_r   <= dec_s[4];
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign ALUctrl   = alu_ctrl_r;
    assign illegal   = illegal_r;

`ifdef ALU_CTRL_MULDIV_EN
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             md_div_r, md_div_nxt_s;
    logic             md_uns_r, md_uns_nxt_s;
    logic             hilo_we_r;

    // Sequencer next-state: start on accepted mult/div, count down, abort on flush
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        md_div_nxt_s = md_div_r;
        md_uns_nxt_s = md_uns_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && dec_s[5]) begin
                    state_nxt_s  = ST_BUSY;
                    cnt_nxt_s    = funct[1] ? DIV_LOAD : MUL_LOAD;
                    md_div_nxt_s = funct[1];
                    md_uns_nxt_s = funct[0];
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Sequencer state; hilo_we is registered from the next-state so it marks the final busy cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            md_div_r  <= 1'b0;
            md_uns_r  <= 1'b0;
            hilo_we_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            md_div_r  <= md_div_nxt_s;
            md_uns_r  <= md_uns_nxt_s;
            hilo_we_r <= (state_nxt_s == ST_BUSY) && (cnt_nxt_s == CNT_ZERO);
        end
    end

    assign in_ready    = (state_r == ST_IDLE);
    assign md_busy     = (state_r == ST_BUSY);
    assign md_div      = md_div_r;
    assign md_unsigned = md_uns_r;
    assign hilo_we     = hilo_we_r;
`else
    logic unused_s;
    assign unused_s    = dec_s[5] ^ (^CNT_W'(MUL_CYCLES + DIV_CYCLES));

    assign in_ready    = 1'b1;
    assign md_busy     = 1'b0;
    assign md_div      = 1'b0;
    assign md_unsigned = 1'b0;
    assign hilo_we     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: table-driven reference decode plus a busy-cycle countdown model.
// Follows ALU_CTRL_MULDIV_EN the same way as the design.
module tb_alu_ctrl_seq;

    localparam int MUL_CYCLES = 4;
    localparam int DIV_CYCLES = 32;
`ifdef ALU_CTRL_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, in_valid, in_ready, flush;
    logic [1:0] ALUop;
    logic [5:0] funct, opcode;
    logic       out_valid, illegal, md_busy, md_div, md_unsigned, hilo_we;
    logic [3:0] ALUctrl;

    alu_ctrl_seq #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUop(ALUop), .funct(funct), .opcode(opcode), .flush(flush),
        .out_valid(out_valid), .ALUctrl(ALUctrl), .illegal(illegal),
        .md_busy(md_busy), .md_div(md_div), .md_unsigned(md_unsigned), .hilo_we(hilo_we)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ov;
        logic       rdy;
        logic       busy;
        logic       hwe;
        logic       chk_md;
        logic       mdd;
        logic       mdu;
        logic       chk_ctrl;
        logic [3:0] ctrl;
        logic       ill;
    } ctl_t;

    ctl_t       ctl_q[$];
    logic [4:0] dec_q[$];
    logic [3:0] rmap[logic [5:0]];
    logic [3:0] imap[logic [5:0]];
    int         errors = 0;
    int         checks = 0;
    int         busy_left = 0;
    logic       m_div = 1'b0, m_uns = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void ref_decode(input logic [1:0] aop, input logic [5:0] fn,
                                       input logic [5:0] opc, output logic [3:0] c,
                                       output logic il, output logic md);
        c = 4'b0010; il = 1'b0; md = 1'b0;
        if (aop == 2'b00) c = 4'b0010;
        else if (aop == 2'b01) c = 4'b0110;
        else if (aop == 2'b10) begin
            if (rmap.exists(fn)) begin
                c  = rmap[fn];
                md = (c == 4'b1101) || (c == 4'b1110);
            end else il = 1'b1;
        end else begin
            if (imap.exists(opc)) c = imap[opc];
            else il = 1'b1;
        end
    endfunction

    // One cycle of stimulus: drive inputs, advance the model, queue what must appear after the edge
    task automatic step(input logic rst, input logic v, input logic [1:0] aop,
                        input logic [5:0] fn, input logic [5:0] opc, input logic fl);
        ctl_t e;
        logic [3:0] c;
        logic il, md, acc;
        @(negedge clk); #1;
        reset = rst; in_valid = v; ALUop = aop; funct = fn; opcode = opc; flush = fl;
        ref_decode(aop, fn, opc, c, il, md);
        e = '0;
        if (rst) begin
            busy_left = 0; m_div = 1'b0; m_uns = 1'b0;
            e.chk_md = 1'b1; e.chk_ctrl = 1'b1;
        end else begin
            acc = v && (busy_left == 0) && !fl;
            if (busy_left > 0) busy_left = fl ? 0 : busy_left - 1;
            if (acc) begin
                dec_q.push_back({il, c});
                e.ov = 1'b1;
                if (md) begin
                    busy_left = fn[1] ? DIV_CYCLES : MUL_CYCLES;
                    m_div = fn[1]; m_uns = fn[0];
                end
            end
            e.chk_md = (busy_left > 0);
            e.mdd = m_div; e.mdu = m_uns;
        end
        e.rdy  = (busy_left == 0);
        e.busy = (busy_left > 0);
        e.hwe  = (busy_left == 1);
        ctl_q.push_back(e);
    endtask

    // Monitor: compares every cycle's control outputs and pops decode results whenever out_valid rises
    initial begin
        ctl_t e;
        logic [4:0] d;
        forever begin
            @(negedge clk);
            if (ctl_q.size() > 0) begin
                e = ctl_q.pop_front();
                chk("out_valid", {7'd0, out_valid}, {7'd0, e.ov});
                chk("in_ready", {7'd0, in_ready}, {7'd0, e.rdy});
                chk("md_busy", {7'd0, md_busy}, {7'd0, e.busy});
                chk("hilo_we", {7'd0, hilo_we}, {7'd0, e.hwe});
                if (e.chk_md) begin
                    chk("md_div", {7'd0, md_div}, {7'd0, e.mdd});
                    chk("md_unsigned", {7'd0, md_unsigned}, {7'd0, e.mdu});
                end
                if (e.chk_ctrl) begin
                    chk("reset_ALUctrl", {4'd0, ALUctrl}, {4'd0, e.ctrl});
                    chk("reset_illegal", {7'd0, illegal}, {7'd0, e.ill});
                end
                if (out_valid === 1'b1) begin
                    if (dec_q.size() == 0) begin
                        chk("unexpected_out_valid", 8'd1, 8'd0);
                    end else begin
                        d = dec_q.pop_front();
                        chk("ALUctrl", {4'd0, ALUctrl}, {4'd0, d[3:0]});
                        chk("illegal", {7'd0, illegal}, {7'd0, d[4]});
                    end
                end
            end
        end
    end

    logic [5:0] fkeys[$];
    logic [5:0] okeys[$];

    initial begin
        logic [5:0] fn, opc;
        rmap[6'b100000] = 4'b0010; rmap[6'b100001] = 4'b0010;
        rmap[6'b100010] = 4'b0110; rmap[6'b100011] = 4'b0110;
        rmap[6'b100100] = 4'b0000; rmap[6'b100101] = 4'b0001;
        rmap[6'b100110] = 4'b0011; rmap[6'b100111] = 4'b1100;
        rmap[6'b101010] = 4'b0111; rmap[6'b000000] = 4'b1000;
        rmap[6'b000010] = 4'b1001; rmap[6'b000011] = 4'b1010;
        if (MD_EN) begin
            rmap[6'b011000] = 4'b1101; rmap[6'b011001] = 4'b1101;
            rmap[6'b011010] = 4'b1110; rmap[6'b011011] = 4'b1110;
        end
        imap[6'b001000] = 4'b0010; imap[6'b001001] = 4'b0010;
        imap[6'b001100] = 4'b0000; imap[6'b001101] = 4'b0001;
        imap[6'b001110] = 4'b0011; imap[6'b001010] = 4'b0111;
        imap[6'b001111] = 4'b1011;
        foreach (rmap[k]) fkeys.push_back(k);
        foreach (imap[k]) okeys.push_back(k);
        fkeys.push_back(6'b011000); fkeys.push_back(6'b011011);

        reset = 1'b1; in_valid = 1'b1; ALUop = 2'b10; funct = 6'b100010;
        opcode = 6'b000000; flush = 1'b0;

        // Reset held with a pending SUB, then released
        step(1'b1, 1'b1, 2'b10, 6'b100010, 6'd0, 1'b0);
        step(1'b1, 1'b1, 2'b10, 6'b100010, 6'd0, 1'b0);
        step(1'b0, 1'b1, 2'b10, 6'b100010, 6'd0, 1'b0);

        // Back-to-back decode sweep (non mult/div functs), then illegal codes
        step(1'b0, 1'b1, 2'b00, 6'd0, 6'd0, 1'b0);
        step(1'b0, 1'b1, 2'b01, 6'd0, 6'd0, 1'b0);
        foreach (rmap[k]) if (k[5:2] != 4'b0110) step(1'b0, 1'b1, 2'b10, k, 6'd0, 1'b0);
        foreach (imap[k]) step(1'b0, 1'b1, 2'b11, 6'd0, k, 1'b0);
        step(1'b0, 1'b1, 2'b10, 6'b111111, 6'd0, 1'b0);
        step(1'b0, 1'b1, 2'b11, 6'd0, 6'b000000, 1'b0);

        // MULT followed by a held ADD
        step(1'b0, 1'b1, 2'b10, 6'b011000, 6'd0, 1'b0);
        for (int i = 0; i < MUL_CYCLES + 2; i++) step(1'b0, 1'b1, 2'b10, 6'b100000, 6'd0, 1'b0);

        // DIVU to completion
        step(1'b0, 1'b1, 2'b10, 6'b011011, 6'd0, 1'b0);
        for (int i = 0; i < DIV_CYCLES + 2; i++) step(1'b0, 1'b0, 2'b10, 6'b100000, 6'd0, 1'b0);

        // DIV aborted by flush in its second busy cycle, then flush dropping an ADD
        step(1'b0, 1'b1, 2'b10, 6'b011010, 6'd0, 1'b0);
        step(1'b0, 1'b0, 2'b10, 6'b100000, 6'd0, 1'b0);
        step(1'b0, 1'b0, 2'b10, 6'b100000, 6'd0, 1'b1);
        step(1'b0, 1'b1, 2'b10, 6'b100000, 6'd0, 1'b1);
        step(1'b0, 1'b0, 2'b10, 6'b100000, 6'd0, 1'b0);

        // Reset in the middle of a MULT
        step(1'b0, 1'b1, 2'b10, 6'b011001, 6'd0, 1'b0);
        step(1'b0, 1'b0, 2'b10, 6'b100000, 6'd0, 1'b0);
        step(1'b1, 1'b1, 2'b10, 6'b100000, 6'd0, 1'b1);
        step(1'b0, 1'b0, 2'b10, 6'b100000, 6'd0, 1'b0);

        // Randomized traffic biased toward legal codes
        for (int i = 0; i < 600; i++) begin
            fn  = ($urandom_range(0, 3) != 0) ? fkeys[$urandom_range(0, fkeys.size() - 1)]
                                              : 6'($urandom_range(0, 63));
            opc = ($urandom_range(0, 3) != 0) ? okeys[$urandom_range(0, okeys.size() - 1)]
                                              : 6'($urandom_range(0, 63));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)), fn, opc, $urandom_range(0, 15) == 0);
        end

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00, 6'd0, 6'd0, 1'b0);
        @(negedge clk); #1;
        chk("decode_queue_drained", 8'(dec_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, parametrised successor to the single-cycle ALU control decoder, sitting at the ID/EX boundary of the pipelined MIPS core. Decodes ALUop/funct/opcode into a 4-bit ALU control word with one cycle of latency. Adds I-type, shift, NOR and XOR decode, an illegal-instruction flag, and a multi-cycle MULT/DIV sequencer that back-pressures the ID stage and pulses the HI/LO write enable.

## Interface
Parameters:
- MUL_CYCLES, 4, EX occupancy of MULT/MULTU in cycles (≥1)
- DIV_CYCLES, 32, EX occupancy of DIV/DIVU in cycles (≥1)
- CNT_W, 6, sequencer counter width; must hold max(MUL_CYCLES, DIV_CYCLES)-1

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  block accepts this cycle; transfer = in_valid & in_ready
- ALUop  in  2  00 mem, 01 branch, 10 R-type, 11 I-type (use opcode)
- funct  in  6  R-type function field
- opcode  in  6  instruction opcode
- flush  in  1  kill output stage and abort sequencer
- out_valid  out  1  registered decode valid
- ALUctrl  out  4  registered ALU control
- illegal  out  1  registered; unsupported funct/opcode (valid only with out_valid)
- md_busy  out  1  sequencer occupied
- md_div  out  1  active op is DIV/DIVU
- md_unsigned  out  1  active op is MULTU/DIVU
- hilo_we  out  1  one-cycle HI/LO write pulse

## Operation
- Encoding: 0000 and, 0001 or, 0010 add, 0011 xor, 0110 sub, 0111 slt, 1000 sll, 1001 srl, 1010 sra, 1011 lui, 1100 nor, 1101 mult, 1110 div.
- ALUop 00 -> 0010; 01 -> 0110.
- ALUop 10, funct: 100000/100001 add, 100010/100011 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 000000 sll, 000010 srl, 000011 sra, 011000/011001 mult, 011010/011011 div.
- ALUop 11, opcode: 001000/001001 add, 001100 and, 001101 or, 001110 xor, 001010 slt, 001111 lui.
- Anything else -> ALUctrl 0010, illegal=1.
- Sequencer states IDLE, BUSY. IDLE: in_ready=1. Transfer of a mult/div op -> BUSY, counter loaded with MUL_CYCLES-1 or DIV_CYCLES-1; md_div/md_unsigned latched from funct[1]/funct[0].
- BUSY: in_ready=0, md_busy=1; counter decrements each cycle; on count==0, hilo_we=1 and next state IDLE.
- flush: out_valid cleared next edge; BUSY -> IDLE with no hilo_we; flush with in_valid drops the input (flush wins).
- Transfer with no flush loads ALUctrl/illegal and sets out_valid; no transfer clears out_valid; ALUctrl/illegal hold last value.

## Timing
- Reset values: out_valid 0, ALUctrl 0000, illegal 0, md_busy 0, md_div 0, md_unsigned 0, hilo_we 0; state IDLE, counter 0. reset overrides flush and in_valid; reset mid-BUSY aborts with no hilo_we.
- Decode latency 1: transfer at edge N -> out_valid/ALUctrl at N+1.
- Mult/div accepted at edge N: md_busy high cycles N+1..N+LAT, hilo_we high only in cycle N+LAT, in_ready high again in cycle N+LAT+1. LAT=1: single BUSY cycle with hilo_we.
- in_ready is a pure function of state (no combinational path from in_valid).
- hilo_we depends only on registered state (count==0 in BUSY).

## Configuration
- ALU_CTRL_MULDIV_EN defined: sequencer, md_* and hilo_we behave as above.
- Undefined: no sequencer logic; functs 0110xx decode as illegal (ALUctrl 0010); in_ready tied 1; md_busy, md_div, md_unsigned, hilo_we tied 0.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1, ALUop=10, funct=100010 -> all outputs at reset values, then release: out_valid=1, ALUctrl=0110 one cycle later.
- Decode sweep: every listed funct/opcode back-to-back at in_valid=1 -> each ALUctrl appears one cycle later, illegal=0; funct 100111 -> 1100; funct 111111 -> 0010, illegal=1.
- MULT (MUL_CYCLES=4): accept at N -> md_busy cycles N+1..N+4, hilo_we only at N+4, md_unsigned=0, md_div=0, in_ready=0 during BUSY; held ADD accepted at N+5.
- DIVU (DIV_CYCLES=32): md_div=1, md_unsigned=1, exactly one hilo_we after 32 busy cycles.
- Flush at BUSY cycle 2 of a DIV -> IDLE next cycle, no hilo_we, out_valid=0; flush with in_valid=1, ADD -> input dropped.
- Macro undefined: MULT -> ALUctrl=0010, illegal=1, in_ready stays 1, hilo_we never asserts.
